// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sad_pkg
//  Brief    : Shared types and helpers for the SAD pipeline: FSM state
//             encoding and the default result-width function.
//  Revision : 1.0  initial release
// ============================================================================
package sad_pkg;

  // Sequencer states of sad_pipe
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sad_state_t;

  // Smallest result width that can never overflow: one pixel-difference
  // width plus one bit per doubling of the pixel count.
  function automatic int sad_w_default(input int pix_w, input int n_pix);
    return pix_w + $clog2(n_pix);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sad_lane_tree.sv
`default_nettype none
// ============================================================================
//  Module   : sad_lane_tree
//  Brief    : Stage 1 of the SAD pipeline. Registers the unsigned absolute
//             difference of every lane, then sums the registered lanes
//             combinationally for the accumulator stage.
//  Revision : 1.0  initial release
// ============================================================================
module sad_lane_tree #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int SUM_W = PIX_W + $clog2(LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [LANES*PIX_W-1:0]   a_data,
  input  logic [LANES*PIX_W-1:0]   b_data,
  output logic                     vld,
  output logic [SUM_W-1:0]         sum
);

  logic [PIX_W-1:0] w_abs  [LANES];
  logic [PIX_W-1:0] diff_d [LANES];
  logic [PIX_W-1:0] diff_q [LANES];
  logic             vld_d;
  logic             vld_q;
  logic [SUM_W-1:0] w_sum;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PIX_W-1:0] w_a;
    logic [PIX_W-1:0] w_b;
    assign w_a      = a_data[i*PIX_W +: PIX_W];
    assign w_b      = b_data[i*PIX_W +: PIX_W];
    // Subtract the smaller from the larger so the result never needs a sign bit
    assign w_abs[i] = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
  end

  // Next-state for the lane registers: capture only when memory data is valid
  always_comb begin
    vld_d = en;
    for (int i = 0; i < LANES; i++) begin
      diff_d[i] = en ? w_abs[i] : diff_q[i];
    end
  end

  // Stage-1 lane registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        diff_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < LANES; i++) begin
        diff_q[i] <= diff_d[i];
      end
    end
  end

  // Adder tree over the registered lane differences
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + SUM_W'(diff_q[i]);
    end
  end

  assign vld = vld_q;
  assign sum = w_sum;

endmodule
`default_nettype wire

// File: rtl/sad_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : sad_pipe
//  Brief    : Sum of absolute differences between two pixel blocks read
//             word by word from two 1-cycle-latency memories sharing one
//             address. Result is published with a one-cycle done pulse.
//             Config macro SAD_PIPE_SAT_EN: accumulator saturates at
//             2^SAD_W-1 instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
module sad_pipe
  import sad_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int N_PIX = 256,
  parameter int SAD_W = sad_w_default(PIX_W, N_PIX)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   go,
  input  logic [LANES*PIX_W-1:0]                 A_data,
  input  logic [LANES*PIX_W-1:0]                 B_data,
  output logic [$clog2(N_PIX/LANES)-1:0]         AB_addr,
  output logic                                   AB_rd,
  output logic                                   busy,
  output logic                                   done,
  output logic [SAD_W-1:0]                       sad
);

  localparam int W      = N_PIX / LANES;
  localparam int ADDR_W = $clog2(W);
  localparam int SUM_W  = PIX_W + $clog2(LANES);
  localparam int EXT_W  = ((SAD_W > SUM_W) ? SAD_W : SUM_W) + 1;
  localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(W - 1);
  localparam logic [SAD_W-1:0]  C_SAD_MAX = '1;

  sad_state_t        state_q,  state_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              rd_q,     rd_d;
  logic              rd_dly_q, rd_dly_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              drain_q,  drain_d;
  logic [SAD_W-1:0]  acc_q,    acc_d;
  logic [SAD_W-1:0]  sad_q,    sad_d;

  logic              w_vld;
  logic [SUM_W-1:0]  w_sum;
  logic [EXT_W-1:0]  w_ext;
  logic [SAD_W-1:0]  w_acc_upd;
  logic [SAD_W-1:0]  w_acc_nx;

  // Data for an address arrives the cycle after issue, so the lane stage is
  // enabled by the read strobe delayed one cycle.
  sad_lane_tree #(
    .PIX_W (PIX_W),
    .LANES (LANES),
    .SUM_W (SUM_W)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .en     (rd_dly_q),
    .a_data (A_data),
    .b_data (B_data),
    .vld    (w_vld),
    .sum    (w_sum)
  );

  // Accumulator update in a widened domain, then wrap or clamp to SAD_W
  always_comb begin
    w_ext = EXT_W'(acc_q) + EXT_W'(w_sum);
`ifdef SAD_PIPE_SAT_EN
    w_acc_upd = (w_ext > EXT_W'(C_SAD_MAX)) ? C_SAD_MAX : w_ext[SAD_W-1:0];
`else
    w_acc_upd = w_ext[SAD_W-1:0];
`endif
    w_acc_nx = w_vld ? w_acc_upd : acc_q;
  end

  // Sequencer next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    addr_d   = '0;
    rd_d     = 1'b0;
    rd_dly_d = rd_q;
    done_d   = 1'b0;
    drain_d  = drain_q;
    acc_d    = w_acc_nx;
    sad_d    = sad_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_RUN;
          rd_d    = 1'b1;
          acc_d   = '0;
        end
      end
      S_RUN: begin
        if (addr_q == C_LAST) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          rd_d   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // Second drain cycle retires the last word; publish the final total
        if (drain_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          sad_d   = w_acc_nx;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, address, strobe, accumulator and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      rd_dly_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drain_q  <= 1'b0;
      acc_q    <= '0;
      sad_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      rd_dly_q <= rd_dly_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drain_q  <= drain_d;
      acc_q    <= acc_d;
      sad_q    <= sad_d;
    end
  end

  assign AB_addr = addr_q;
  assign AB_rd   = rd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sad     = sad_q;

endmodule
`default_nettype wire

// File: tb/tb_sad_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sad_pipe
//  Brief    : Self-checking bench for sad_pipe. Three instances cover the
//             default build, a narrow 12-bit result and a single-lane block.
//             Expected sums come from a pixel-level model over shared arrays.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sad_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go_drv = 1'b0;
  int   cur = 0;

  always #5 clk = ~clk;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  int n_checks = 0;
  int n_errors = 0;

`ifdef SAD_PIPE_SAT_EN
  localparam longint EXP_D1_OVF = 4095;
`else
  localparam longint EXP_D1_OVF = 3840;
`endif

  // instance 0: defaults
  logic        go0, rd0, busy0, done0;
  logic [31:0] a0, b0;
  logic [5:0]  addr0;
  logic [5:0]  ra0 = '0;
  logic [15:0] sad0;
  // instance 1: 12-bit result
  logic        go1, rd1, busy1, done1;
  logic [31:0] a1, b1;
  logic [5:0]  addr1;
  logic [5:0]  ra1 = '0;
  logic [11:0] sad1;
  // instance 2: one lane, 16 pixels
  logic        go2, rd2, busy2, done2;
  logic [7:0]  a2, b2;
  logic [3:0]  addr2;
  logic [3:0]  ra2 = '0;
  logic [15:0] sad2;

  assign go0 = go_drv & (cur == 0);
  assign go1 = go_drv & (cur == 1);
  assign go2 = go_drv & (cur == 2);

  sad_pipe u_d0 (
    .clk(clk), .rst(rst), .go(go0), .A_data(a0), .B_data(b0),
    .AB_addr(addr0), .AB_rd(rd0), .busy(busy0), .done(done0), .sad(sad0)
  );
  sad_pipe #(.SAD_W(12)) u_d1 (
    .clk(clk), .rst(rst), .go(go1), .A_data(a1), .B_data(b1),
    .AB_addr(addr1), .AB_rd(rd1), .busy(busy1), .done(done1), .sad(sad1)
  );
  sad_pipe #(.LANES(1), .N_PIX(16), .SAD_W(16)) u_d2 (
    .clk(clk), .rst(rst), .go(go2), .A_data(a2), .B_data(b2),
    .AB_addr(addr2), .AB_rd(rd2), .busy(busy2), .done(done2), .sad(sad2)
  );

  // memories: registered read address, one cycle latency
  always @(posedge clk) begin
    if (rd0) ra0 <= addr0;
    if (rd1) ra1 <= addr1;
    if (rd2) ra2 <= addr2;
  end

  always_comb begin
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    for (int i = 0; i < 4; i++) begin
      a0[i*8 +: 8] = mem_a[int'(ra0)*4 + i];
      b0[i*8 +: 8] = mem_b[int'(ra0)*4 + i];
      a1[i*8 +: 8] = mem_a[int'(ra1)*4 + i];
      b1[i*8 +: 8] = mem_b[int'(ra1)*4 + i];
    end
    a2 = mem_a[int'(ra2)];
    b2 = mem_b[int'(ra2)];
  end

  // view of the instance under test
  logic        m_rd, m_busy, m_done;
  logic [31:0] m_addr, m_sad;
  always_comb begin
    m_rd = rd0; m_busy = busy0; m_done = done0;
    m_addr = 32'(addr0); m_sad = 32'(sad0);
    if (cur == 1) begin
      m_rd = rd1; m_busy = busy1; m_done = done1;
      m_addr = 32'(addr1); m_sad = 32'(sad1);
    end else if (cur == 2) begin
      m_rd = rd2; m_busy = busy2; m_done = done2;
      m_addr = 32'(addr2); m_sad = 32'(sad2);
    end
  end

  int npix [3] = '{256, 256, 16};
  int sadw [3] = '{16, 12, 16};
  int wcnt [3] = '{64, 64, 16};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // mode 0: constant A/B, mode 1: ramp A=i B=2i, mode 2: random
  task automatic fill(input int mode, input int av, input int bv);
    for (int p = 0; p < 256; p++) begin
      case (mode)
        0: begin mem_a[p] = 8'(av); mem_b[p] = 8'(bv); end
        1: begin mem_a[p] = (p < 16) ? 8'(p) : 8'd0; mem_b[p] = (p < 16) ? 8'(2*p) : 8'd0; end
        default: begin mem_a[p] = 8'($urandom_range(0, 255)); mem_b[p] = 8'($urandom_range(0, 255)); end
      endcase
    end
  endtask

  // reference: plain sum of |a-b| over the block, then clamp or wrap
  function automatic longint ref_sad(input int n, input int sw);
    longint s;
    longint mx;
    s  = 0;
    mx = (longint'(1) << sw) - 1;
    for (int p = 0; p < n; p++) begin
      s += (mem_a[p] > mem_b[p]) ? longint'(mem_a[p] - mem_b[p]) : longint'(mem_b[p] - mem_a[p]);
    end
`ifdef SAD_PIPE_SAT_EN
    if (s > mx) s = mx;
`else
    s = s % (mx + 1);
`endif
    return s;
  endfunction

  // one go pulse on the current instance, tracking the cycle-by-cycle bus
  task automatic run_block(input int w, input bit noisy, output logic [31:0] got_sad,
                           output int lat, output bit seq_ok, output bit hold_ok, output bit idle_ok);
    logic [31:0] prev;
    bit exp_rd;
    int exp_addr;
    seq_ok = 1; hold_ok = 1; idle_ok = 1; lat = -1; got_sad = 'x;
    @(negedge clk);
    prev   = m_sad;
    go_drv = 1'b1;
    @(negedge clk);
    go_drv = 1'b0;
    for (int j = 1; j <= w + 20; j++) begin
      exp_rd   = (j <= w);
      exp_addr = exp_rd ? j - 1 : 0;
      if (m_rd !== exp_rd || m_addr !== 32'(exp_addr) || m_busy !== 1'b1) seq_ok = 0;
      if (m_done === 1'b1) begin
        lat     = j;
        got_sad = m_sad;
        if (noisy) go_drv = 1'b1;
        break;
      end
      if (m_sad !== prev) hold_ok = 0;
      if (noisy) go_drv = (j <= w + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    go_drv = 1'b0;
    if (m_busy !== 1'b0 || m_done !== 1'b0 || m_sad !== got_sad) idle_ok = 0;
    @(negedge clk);
    if (m_busy !== 1'b0 || m_sad !== got_sad) idle_ok = 0;
  endtask

  typedef struct {
    int     sel;
    int     mode;
    int     av;
    int     bv;
    longint exp_sad;   // -1: take from the reference model
    int     exp_lat;
  } vec_t;

  vec_t tab [13];

  initial begin
    logic [31:0] got;
    int lat;
    bit seq_ok, hold_ok, idle_ok, found, saw_done, busy_bad;
    longint exp;
    int t1, t2, idle;
    logic [31:0] s1, s2;

    tab[0]  = '{0, 0, 5,   3,   512,        67};
    tab[1]  = '{0, 0, 0,   255, 65280,      67};
    tab[2]  = '{0, 0, 255, 0,   65280,      67};
    tab[3]  = '{1, 0, 0,   255, EXP_D1_OVF, 67};
    tab[4]  = '{2, 1, 0,   0,   120,        19};
    tab[5]  = '{1, 0, 10,  7,   768,        67};
    tab[6]  = '{2, 0, 255, 0,   4080,       19};
    tab[7]  = '{0, 2, 0,   0,   -1,         67};
    tab[8]  = '{0, 2, 0,   0,   -1,         67};
    tab[9]  = '{0, 2, 0,   0,   -1,         67};
    tab[10] = '{1, 2, 0,   0,   -1,         67};
    tab[11] = '{1, 2, 0,   0,   -1,         67};
    tab[12] = '{2, 2, 0,   0,   -1,         19};

    fill(0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_d0_sad", 64'(sad0), 0);
    check("reset_d0_ctl", 64'({addr0, rd0, busy0, done0}), 0);
    check("reset_d1", 64'({sad1, addr1, rd1, busy1, done1}), 0);
    check("reset_d2", 64'({sad2, addr2, rd2, busy2, done2}), 0);
    rst = 1'b0;

    for (int t = 0; t < 13; t++) begin
      cur = tab[t].sel;
      fill(tab[t].mode, tab[t].av, tab[t].bv);
      exp = (tab[t].exp_sad < 0) ? ref_sad(npix[cur], sadw[cur]) : tab[t].exp_sad;
      run_block(wcnt[cur], (t % 2) == 1, got, lat, seq_ok, hold_ok, idle_ok);
      check($sformatf("vec%0d_sad", t), 64'(got), 64'(exp));
      check($sformatf("vec%0d_latency", t), 64'(lat), 64'(tab[t].exp_lat));
      check($sformatf("vec%0d_addr_seq", t), 64'(seq_ok), 1);
      check($sformatf("vec%0d_no_partial", t), 64'(hold_ok), 1);
      check($sformatf("vec%0d_idle_after", t), 64'(idle_ok), 1);
    end

    // abort at address 20
    cur = 0;
    fill(0, 5, 3);
    @(negedge clk);
    go_drv = 1'b1;
    @(negedge clk);
    go_drv = 1'b0;
    found = 0;
    for (int j = 0; j < 100; j++) begin
      if (m_rd === 1'b1 && m_addr == 32'd20) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("abort_reached_addr20", 64'(found), 1);
    rst = 1'b1;
    #1;
    check("abort_sad_zero", 64'(m_sad), 0);
    check("abort_ctl_zero", 64'({m_addr[15:0], m_rd, m_busy, m_done}), 0);
    saw_done = 0;
    busy_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_done !== 1'b0) saw_done = 1;
    end
    rst = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (m_done !== 1'b0) saw_done = 1;
      if (m_busy !== 1'b0) busy_bad = 1;
    end
    check("abort_no_done", 64'(saw_done), 0);
    check("abort_stays_idle", 64'(busy_bad), 0);
    run_block(64, 1'b0, got, lat, seq_ok, hold_ok, idle_ok);
    check("restart_sad", 64'(got), 512);
    check("restart_latency", 64'(lat), 67);
    check("restart_addr_seq", 64'(seq_ok), 1);

    // go held high: back-to-back runs
    cur = 0;
    fill(2, 0, 0);
    exp = ref_sad(256, 16);
    @(negedge clk);
    go_drv = 1'b1;
    t1 = -1; t2 = -1; idle = 0; s1 = 'x; s2 = 'x;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      if (m_done === 1'b1) begin
        if (t1 < 0) begin
          t1 = j; s1 = m_sad;
        end else begin
          t2 = j; s2 = m_sad; go_drv = 1'b0;
          break;
        end
      end else if (t1 >= 0 && m_busy === 1'b0) begin
        idle++;
      end
    end
    go_drv = 1'b0;
    check("held_first_latency", 64'(t1), 67);
    check("held_period", 64'(t2 - t1), 68);
    check("held_idle_cycles", 64'(idle), 1);
    check("held_sad1", 64'(s1), 64'(exp));
    check("held_sad2", 64'(s2), 64'(exp));
    @(negedge clk);
    check("held_stops", 64'(m_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
